// File: rtl/regfile_param.sv
// regfile_param: parameterised 2-read/1-write register file; after reset a clear sequence zeroes every register before Ready rises
// Ports:
//   Clk, Reset_n         clock and asynchronous active-low reset
//   RA, RB               combinational read addresses -> BusA, BusB
//   RW, BusW, RegWr      synchronous write port
//   Ready                clear sequence done, writes accepted
//   WrDropped            sticky flag: a write was attempted before Ready
module regfile_param #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  input  logic [AW-1:0]    RW,
  input  logic [WIDTH-1:0] BusW,
  input  logic             RegWr,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic             Ready,
  output logic             WrDropped
);
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_e           state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic             wr_dropped_q, wr_dropped_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok, ra_ok, rb_ok;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      wr_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      wr_dropped_q <= wr_dropped_d;
    end
  end
  always_comb begin
    state_d      = (state_q == CLEAR && clr_ptr_q == LAST) ? READY : state_q;
    clr_ptr_d    = (state_q == CLEAR) ? clr_ptr_q + 1'b1 : clr_ptr_q;
    wr_dropped_d = wr_dropped_q | (state_q == CLEAR && RegWr);
  end
  // Indices outside the array or equal to the hard-zero index never read or write storage.
  always_comb begin
    Ready     = state_q == READY;
    WrDropped = wr_dropped_q;
    wr_ok     = Ready && RegWr && 32'(RW) != ZERO_REG && 32'(RW) < DEPTH;
    ra_ok     = Ready && 32'(RA) != ZERO_REG && 32'(RA) < DEPTH;
    rb_ok     = Ready && 32'(RB) != ZERO_REG && 32'(RB) < DEPTH;
    BusA      = !ra_ok ? '0 : (BYPASS != 0 && RegWr && RW == RA) ? BusW : mem_q[RA];
    BusB      = !rb_ok ? '0 : (BYPASS != 0 && RegWr && RW == RB) ? BusW : mem_q[RB];
  end
  // Storage has no reset; the clear sequence walks every entry instead.
  always_ff @(posedge Clk) begin
    if (state_q == CLEAR) mem_q[clr_ptr_q] <= '0;
    else if (wr_ok) mem_q[RW] <= BusW;
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: randomized and directed checks of four regfile_param configurations against an array model
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ra = '0, rb = '0, rw = '0;
  logic [63:0] busw = '0;
  logic        regwr = 1'b0;
  logic [63:0] a0, b0, a1, b1;
  logic [31:0] a2, b2, a3, b3;
  logic        r0, r1, r2, r3, d0, d1, d2, d3;
  int n_cmp = 0;
  int n_err = 0;
  localparam int          DP[4] = '{32, 32, 20, 16};
  localparam int          ZR[4] = '{31, 31, 31, 0};
  localparam int          BY[4] = '{1, 0, 1, 1};
  localparam int          AM[4] = '{31, 31, 31, 15};
  localparam logic [63:0] WM[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                   64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
  logic [63:0] mdl [4][32];
  int          cnt [4];
  logic        dropped [4];
  always #5 clk = ~clk;
  regfile_param u0 (.Clk(clk), .Reset_n(rst_n), .RA(ra), .RB(rb), .RW(rw), .BusW(busw),
    .RegWr(regwr), .BusA(a0), .BusB(b0), .Ready(r0), .WrDropped(d0));
  regfile_param #(.BYPASS(0)) u1 (.Clk(clk), .Reset_n(rst_n), .RA(ra), .RB(rb), .RW(rw),
    .BusW(busw), .RegWr(regwr), .BusA(a1), .BusB(b1), .Ready(r1), .WrDropped(d1));
  regfile_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(31), .BYPASS(1)) u2 (.Clk(clk),
    .Reset_n(rst_n), .RA(ra), .RB(rb), .RW(rw), .BusW(busw[31:0]), .RegWr(regwr),
    .BusA(a2), .BusB(b2), .Ready(r2), .WrDropped(d2));
  regfile_param #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0), .BYPASS(1)) u3 (.Clk(clk),
    .Reset_n(rst_n), .RA(ra[3:0]), .RB(rb[3:0]), .RW(rw[3:0]), .BusW(busw[31:0]),
    .RegWr(regwr), .BusA(a3), .BusB(b3), .Ready(r3), .WrDropped(d3));
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [63:0] exp_rd(int k, logic [4:0] addr);
    int a = int'(addr) & AM[k];
    int w = int'(rw) & AM[k];
    if (cnt[k] < DP[k] || a == ZR[k] || a >= DP[k]) return '0;
    if (BY[k] != 0 && regwr && w == a) return busw & WM[k];
    return mdl[k][a];
  endfunction
  function automatic logic [63:0] exp_rdy(int k);
    return 64'(cnt[k] >= DP[k]);
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) mdl[k][i] = '0;
      cnt[k] = 0;
      dropped[k] = 1'b0;
    end
  endtask
  task automatic model_edge();
    if (!rst_n) model_reset();
    else for (int k = 0; k < 4; k++) begin
      int w = int'(rw) & AM[k];
      if (cnt[k] < DP[k]) begin
        if (regwr) dropped[k] = 1'b1;
        cnt[k]++;
      end else if (regwr && w != ZR[k] && w < DP[k]) mdl[k][w] = busw & WM[k];
    end
  endtask
  task automatic check_all();
    chk("u0.BusA", a0, exp_rd(0, ra));
    chk("u0.BusB", b0, exp_rd(0, rb));
    chk("u0.Ready", 64'(r0), exp_rdy(0));
    chk("u0.WrDropped", 64'(d0), 64'(dropped[0]));
    chk("u1.BusA", a1, exp_rd(1, ra));
    chk("u1.BusB", b1, exp_rd(1, rb));
    chk("u1.Ready", 64'(r1), exp_rdy(1));
    chk("u1.WrDropped", 64'(d1), 64'(dropped[1]));
    chk("u2.BusA", 64'(a2), exp_rd(2, ra));
    chk("u2.BusB", 64'(b2), exp_rd(2, rb));
    chk("u2.Ready", 64'(r2), exp_rdy(2));
    chk("u2.WrDropped", 64'(d2), 64'(dropped[2]));
    chk("u3.BusA", 64'(a3), exp_rd(3, ra));
    chk("u3.BusB", 64'(b3), exp_rd(3, rb));
    chk("u3.Ready", 64'(r3), exp_rdy(3));
    chk("u3.WrDropped", 64'(d3), 64'(dropped[3]));
  endtask
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic wr(logic [4:0] addr, logic [63:0] data);
    regwr = 1'b1;
    rw = addr;
    busw = data;
    ra = 5'($urandom);
    rb = 5'($urandom);
    cycle();
    regwr = 1'b0;
  endtask
  initial begin
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      regwr = (i == 1);
      rw = 5'd3;
      busw = 64'hAA;
      ra = 5'($urandom);
      rb = 5'($urandom);
      cycle();
    end
    regwr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      rb = 5'(31 - i);
      cycle();
    end
    wr(5'd5, 64'hDEAD_BEEF_0123_4567);
    ra = 5'd5;
    rb = 5'd6;
    cycle();
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    ra = 5'd31;
    cycle();
    wr(5'd25, 64'h77);
    ra = 5'd25;
    rb = 5'd9;
    cycle();
    wr(5'd7, 64'h77);
    regwr = 1'b1;
    rw = 5'd7;
    ra = 5'd7;
    rb = 5'd7;
    busw = 64'h1234;
    cycle();
    regwr = 1'b0;
    cycle();
    for (int i = 0; i < 400; i++) begin
      regwr = 1'($urandom);
      rw = 5'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
      busw = {$urandom, $urandom};
      cycle();
    end
    regwr = 1'b0;
    wr(5'd2, 64'h55);
    ra = 5'd2;
    rb = 5'd2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      ra = 5'd2;
      rb = 5'($urandom);
      cycle();
    end
    for (int i = 0; i < 150; i++) begin
      regwr = 1'($urandom);
      rw = 5'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom);
      rb = 5'($urandom);
      busw = {$urandom, $urandom};
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
